joystick_dir_decoder: RTL and testbench

JOYSTICK_DIR_DECODER -- requirements
Module: joystick_dir_decoder

---
 rtl/joystick_dir_decoder_if.sv | 21 ++
 rtl/joystick_dir_decoder.sv | 118 +++++++++++
 tb/tb_joystick_dir_decoder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/joystick_dir_decoder_if.sv
// rtl/joystick_dir_decoder_if.sv - joystick button inputs and committed-direction outputs
interface joystick_dir_decoder_if;
    logic       btn_up;
    logic       btn_right;
    logic       btn_down;
    logic       btn_left;
    logic       step_tick;
    logic [1:0] direction;
    logic       dir_changed;
    logic       any_pressed;

    modport master (
        output btn_up, btn_right, btn_down, btn_left, step_tick,
        input  direction, dir_changed, any_pressed
    );

    modport slave (
        input  btn_up, btn_right, btn_down, btn_left, step_tick,
        output direction, dir_changed, any_pressed
    );
endinterface

// File: rtl/joystick_dir_decoder.sv
// rtl/joystick_dir_decoder.sv - debounced joystick to snake direction with step-aligned commit
module joystick_dir_decoder #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                 clk,
    input  logic                 reset,
    joystick_dir_decoder_if.slave js
);
    localparam logic [1:0] TOP_DIR    = 2'd0;
    localparam logic [1:0] RIGHT_DIR  = 2'd1;
    localparam logic [1:0] BOTTOM_DIR = 2'd2;
    localparam logic [1:0] LEFT_DIR   = 2'd3;

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // bit order: 0 = up, 1 = right, 2 = down, 3 = left (also the priority order)
    logic [3:0]       raw;
    logic [3:0]       sync_a;
    logic [3:0]       sync_b;
    logic [3:0]       debounced;
    logic [CNT_W-1:0] cnt [4];
    logic [3:0]       accept;
    logic [3:0]       press;

    logic [1:0] direction_q;
    logic       dir_changed_q;
    logic [1:0] pending;
    logic       pending_valid;

    logic       cand_hit;
    logic [1:0] cand;
    logic       commit;
    logic [1:0] ref_dir;
    logic       cand_ok;

    assign raw = {js.btn_left, js.btn_down, js.btn_right, js.btn_up};

    always_comb begin
        accept = '0;
        for (int i = 0; i < 4; i++) begin
            accept[i] = (sync_b[i] != debounced[i]) && (cnt[i] == CNT_LAST);
        end
    end

    // A press is the cycle in which a high level is accepted; releases are ignored
    assign press = accept & sync_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a    <= '0;
            sync_b    <= '0;
            debounced <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            for (int i = 0; i < 4; i++) begin
                if (accept[i]) begin
                    debounced[i] <= sync_b[i];
                    cnt[i]       <= '0;
                end else if (sync_b[i] != debounced[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        cand = TOP_DIR;
        if (press[0]) begin
            cand = TOP_DIR;
        end else if (press[1]) begin
            cand = RIGHT_DIR;
        end else if (press[2]) begin
            cand = BOTTOM_DIR;
        end else if (press[3]) begin
            cand = LEFT_DIR;
        end
    end

    assign cand_hit = |press;
    assign commit   = js.step_tick && pending_valid;
    // Judge the candidate against the direction the snake will actually have after this cycle
    assign ref_dir  = commit ? pending : direction_q;
    assign cand_ok  = cand_hit && (cand != ref_dir) && (cand != (ref_dir ^ 2'b10));

    always_ff @(posedge clk) begin
        if (reset) begin
            direction_q   <= TOP_DIR;
            dir_changed_q <= 1'b0;
            pending       <= TOP_DIR;
            pending_valid <= 1'b0;
        end else begin
            if (commit) begin
                direction_q   <= pending;
                dir_changed_q <= (pending != direction_q);
            end else begin
                dir_changed_q <= 1'b0;
            end

            if (cand_ok) begin
                pending       <= cand;
                pending_valid <= 1'b1;
            end else if (js.step_tick) begin
                pending_valid <= 1'b0;
            end
        end
    end

    assign js.direction   = direction_q;
    assign js.dir_changed = dir_changed_q;
    assign js.any_pressed = |debounced;
endmodule

// File: tb/tb_joystick_dir_decoder.sv
// tb/tb_joystick_dir_decoder.sv - scoreboard bench for joystick_dir_decoder
module tb_joystick_dir_decoder;
    localparam logic [1:0] TOP_DIR    = 2'd0;
    localparam logic [1:0] RIGHT_DIR  = 2'd1;
    localparam logic [1:0] BOTTOM_DIR = 2'd2;
    localparam logic [1:0] LEFT_DIR   = 2'd3;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    logic [1:0] dir_q [$];
    int         any_q [$];

    joystick_dir_decoder_if js_if ();

    joystick_dir_decoder #(.DEBOUNCE_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .js    (js_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_btn(input int idx, input logic v);
        case (idx)
            0: js_if.btn_up    = v;
            1: js_if.btn_right = v;
            2: js_if.btn_down  = v;
            default: js_if.btn_left = v;
        endcase
    endtask

    task automatic press_release(input int idx);
        set_btn(idx, 1'b1);
        any_q.push_back(cyc + 6);
        wait_n(8);
        set_btn(idx, 1'b0);
        wait_n(8);
    endtask

    task automatic step_pulse();
        js_if.step_tick = 1'b1;
        tick();
        js_if.step_tick = 1'b0;
    endtask

    // Monitor: every dir_changed pulse and every any_pressed rise must match a queued expectation
    logic       any_prev = 1'b0;
    logic [1:0] dir_prev = TOP_DIR;
    always @(negedge clk) begin
        if (mon_en) begin
            if (js_if.dir_changed === 1'b1) begin
                checks++;
                if (dir_q.size() == 0) begin
                    errors++;
                    $display("FAIL dir_changed_unexpected: got direction %0d at cycle %0d expected no pulse", js_if.direction, cyc);
                end else begin
                    logic [1:0] exp_dir;
                    exp_dir = dir_q.pop_front();
                    if (js_if.direction !== exp_dir) begin
                        errors++;
                        $display("FAIL commit_direction: got %0d expected %0d", js_if.direction, exp_dir);
                    end
                end
            end
            if (js_if.direction !== dir_prev) begin
                checks++;
                if (js_if.direction === (dir_prev ^ 2'b10)) begin
                    errors++;
                    $display("FAIL reversal: got %0d expected not opposite of %0d", js_if.direction, dir_prev);
                end
            end
            if (js_if.any_pressed === 1'b1 && !any_prev) begin
                checks++;
                if (any_q.size() == 0) begin
                    errors++;
                    $display("FAIL any_pressed_unexpected: got rise at cycle %0d expected none", cyc);
                end else begin
                    int exp_cyc;
                    exp_cyc = any_q.pop_front();
                    if (cyc != exp_cyc) begin
                        errors++;
                        $display("FAIL any_pressed_latency: got rise at cycle %0d expected %0d", cyc, exp_cyc);
                    end
                end
            end
            any_prev = (js_if.any_pressed === 1'b1);
            dir_prev = js_if.direction;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int r;
        reset = 1'b1;
        js_if.btn_up = 1'b0;
        js_if.btn_right = 1'b0;
        js_if.btn_down = 1'b0;
        js_if.btn_left = 1'b0;
        js_if.step_tick = 1'b0;
        wait_n(3);
        reset = 1'b0;
        mon_en = 1'b1;
        check("reset_direction", int'(js_if.direction), int'(TOP_DIR));
        check("reset_dir_changed", int'(js_if.dir_changed), 0);
        check("reset_any_pressed", int'(js_if.any_pressed), 0);

        // Idle with step pulses
        repeat (5) begin
            wait_n(3);
            step_pulse();
        end
        check("idle_direction", int'(js_if.direction), int'(TOP_DIR));
        check("idle_any_pressed", int'(js_if.any_pressed), 0);

        // 3-cycle glitch must be filtered
        js_if.btn_right = 1'b1;
        wait_n(3);
        js_if.btn_right = 1'b0;
        wait_n(10);
        check("glitch_any_pressed", int'(js_if.any_pressed), 0);
        step_pulse();
        check("glitch_direction", int'(js_if.direction), int'(TOP_DIR));

        // Clean press: any_pressed at edge+6, commit three cycles later
        js_if.btn_right = 1'b1;
        any_q.push_back(cyc + 6);
        wait_n(9);
        dir_q.push_back(RIGHT_DIR);
        step_pulse();
        check("right_dir_changed_hi", int'(js_if.dir_changed), 1);
        tick();
        check("right_dir_changed_lo", int'(js_if.dir_changed), 0);
        check("right_direction", int'(js_if.direction), int'(RIGHT_DIR));
        js_if.btn_right = 1'b0;
        wait_n(8);

        // Opposite rejected, then last valid press wins
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset2_direction", int'(js_if.direction), int'(TOP_DIR));
        press_release(2);
        step_pulse();
        check("opposite_direction", int'(js_if.direction), int'(TOP_DIR));
        press_release(3);
        press_release(1);
        dir_q.push_back(RIGHT_DIR);
        step_pulse();
        check("last_wins_direction", int'(js_if.direction), int'(RIGHT_DIR));
        wait_n(2);

        // Simultaneous up+left from RIGHT: up wins, left is dropped
        js_if.btn_up = 1'b1;
        js_if.btn_left = 1'b1;
        any_q.push_back(cyc + 6);
        wait_n(8);
        js_if.btn_up = 1'b0;
        js_if.btn_left = 1'b0;
        wait_n(8);
        dir_q.push_back(TOP_DIR);
        step_pulse();
        check("priority_direction", int'(js_if.direction), int'(TOP_DIR));
        wait_n(2);
        step_pulse();
        check("left_not_pending", int'(js_if.direction), int'(TOP_DIR));
        wait_n(2);

        // Pending RIGHT discarded by reset; held button requalifies from zero
        js_if.btn_right = 1'b1;
        any_q.push_back(cyc + 6);
        wait_n(8);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        r = cyc;
        any_q.push_back(r + 6);
        wait_n(3);
        step_pulse();
        check("post_reset_direction", int'(js_if.direction), int'(TOP_DIR));
        check("post_reset_dir_changed", int'(js_if.dir_changed), 0);
        wait_n(4);
        dir_q.push_back(RIGHT_DIR);
        step_pulse();
        check("requalified_direction", int'(js_if.direction), int'(RIGHT_DIR));
        js_if.btn_right = 1'b0;
        wait_n(10);

        check("dir_queue_drained", dir_q.size(), 0);
        check("any_queue_drained", any_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
